// File: rtl/control_unit_pkg.sv
// Shared ISA constants, control encodings and FSM state type for the 16-bit multicycle core.
// Pure declarations; no latency or flow-control behaviour of its own.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 4;
  localparam logic [15:0] NOP_INSTR = 16'h7000;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_NOP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_CONST2 = 2'b01;
  localparam logic [1:0] SRCB_OFFSET = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_ADDR,
    ST_MEM_RD,
    ST_WB_LW,
    ST_MEM_WR,
    ST_BRANCH,
    ST_HALT
  } ctrl_state_t;

  typedef struct packed {
    logic       reg_dst_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath/memory: IR source, memory handshake, addresses, strobes.
// Master = control unit; slave = datapath side that consumes controls and supplies mem data/ready.
interface control_unit_if #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
);
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              zero;

  logic [RA_W-1:0]   A_ReadReg1RT;
  logic [RA_W-1:0]   A_ReadReg2RT;
  logic [RA_W-1:0]   A_Offset;
  logic [RA_W-1:0]   A_RegSWLW;
  logic [RA_W-1:0]   A_WriteRegRT_BT;

  logic              C_RegDstWrite;
  logic              C_RegWrite;
  logic              C_MemToReg;
  logic              C_MemRead;
  logic              C_MemWrite;
  logic              C_IorD;
  logic              C_IRWrite;
  logic              C_PCWrite;
  logic              C_PCWriteCond;
  logic [1:0]        C_ALUSrcB;
  logic [1:0]        C_ALUOp;
  logic              halted;
  logic              illegal;

  modport master (
    input  mem_rdata, mem_ready, zero,
    output A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT,
    output C_RegDstWrite, C_RegWrite, C_MemToReg, C_MemRead, C_MemWrite, C_IorD,
    output C_IRWrite, C_PCWrite, C_PCWriteCond, C_ALUSrcB, C_ALUOp, halted, illegal
  );

  modport slave (
    output mem_rdata, mem_ready, zero,
    input  A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT,
    input  C_RegDstWrite, C_RegWrite, C_MemToReg, C_MemRead, C_MemWrite, C_IorD,
    input  C_IRWrite, C_PCWrite, C_PCWriteCond, C_ALUSrcB, C_ALUOp, halted, illegal
  );
endinterface

// File: rtl/control_unit_instr_field_decode.sv
// Combinational IR -> register-file address fields and opcode class flags; zero latency, no flow control.
module instr_field_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4
) (
  input  logic [DATA_W-1:0] ir,
  output logic [RA_W-1:0]   read_reg1,
  output logic [RA_W-1:0]   read_reg2,
  output logic [RA_W-1:0]   offset,
  output logic [RA_W-1:0]   reg_swlw,
  output logic [RA_W-1:0]   write_reg,
  output logic              is_rtype,
  output logic              is_lw,
  output logic              is_sw,
  output logic              is_beq,
  output logic              is_halt,
  output logic              is_illegal
);

  logic [3:0] op;
  assign op = ir[DATA_W-1 -: 4];

  always_comb begin
    is_rtype   = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype = 1'b1;
      OP_LW:   is_lw   = 1'b1;
      OP_SW:   is_sw   = 1'b1;
      OP_BEQ:  is_beq  = 1'b1;
      OP_NOP:  ;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  // BEQ places its two source registers one field higher than R-type/LW/SW
  assign read_reg1 = is_beq ? ir[2*RA_W +: RA_W] : ir[RA_W +: RA_W];
  assign read_reg2 = is_beq ? ir[RA_W +: RA_W]   : ir[0 +: RA_W];
  assign offset    = ir[0 +: RA_W];
  assign reg_swlw  = ir[2*RA_W +: RA_W];
  assign write_reg = ir[2*RA_W +: RA_W];

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM + IR: FETCH->DECODE->... 2..5 cycles per instruction plus memory wait cycles.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready, holding strobes and suppressing register/PC writes.
module control_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int RA_W   = cpu_pkg::RA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic clk,
  input  logic rst,
  control_unit_if.master bus
);
  import cpu_pkg::*;

  ctrl_state_t       state, state_nxt;
  logic [DATA_W-1:0] ir;
  ctrl_t             ctrl, ctrl_out;

  logic is_rtype, is_lw, is_sw, is_beq, is_halt, is_illegal;

  instr_field_decode #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_decode (
    .ir         (ir),
    .read_reg1  (bus.A_ReadReg1RT),
    .read_reg2  (bus.A_ReadReg2RT),
    .offset     (bus.A_Offset),
    .reg_swlw   (bus.A_RegSWLW),
    .write_reg  (bus.A_WriteRegRT_BT),
    .is_rtype   (is_rtype),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      if (ctrl.ir_write) ir <= bus.mem_rdata;
    end
  end

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_CONST2;
        ctrl.alu_op    = ALUOP_ADD;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_nxt     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_OFFSET;
        if (is_rtype)            state_nxt = ST_EXEC_R;
        else if (is_lw || is_sw) state_nxt = ST_ADDR;
        else if (is_beq)         state_nxt = ST_BRANCH;
        else if (is_halt)        state_nxt = ST_HALT;
        else begin
          ctrl.illegal = is_illegal;
          state_nxt    = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.alu_src_b = SRCB_REG;
        state_nxt      = ST_WB_R;
      end
      ST_WB_R: begin
        ctrl.reg_write     = 1'b1;
        ctrl.reg_dst_write = 1'b1;
        state_nxt          = ST_FETCH;
      end
      ST_ADDR: begin
        ctrl.alu_src_b = SRCB_OFFSET;
        ctrl.alu_op    = ALUOP_ADD;
        state_nxt      = is_lw ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) state_nxt = ST_WB_LW;
      end
      ST_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_nxt       = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) state_nxt = ST_FETCH;
      end
      ST_BRANCH: begin
        // zero-flag gating of the PC write happens in the datapath
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.pc_write_cond = 1'b1;
        state_nxt          = ST_FETCH;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Reset forces every control quiet even in the cycle before state has been cleared
  assign ctrl_out = rst ? '0 : ctrl;

  assign bus.C_RegDstWrite = ctrl_out.reg_dst_write;
  assign bus.C_RegWrite    = ctrl_out.reg_write;
  assign bus.C_MemToReg    = ctrl_out.mem_to_reg;
  assign bus.C_MemRead     = ctrl_out.mem_read;
  assign bus.C_MemWrite    = ctrl_out.mem_write;
  assign bus.C_IorD        = ctrl_out.iord;
  assign bus.C_IRWrite     = ctrl_out.ir_write;
  assign bus.C_PCWrite     = ctrl_out.pc_write;
  assign bus.C_PCWriteCond = ctrl_out.pc_write_cond;
  assign bus.C_ALUSrcB     = ctrl_out.alu_src_b;
  assign bus.C_ALUOp       = ctrl_out.alu_op;
  assign bus.halted        = ctrl_out.halted;
  assign bus.illegal       = ctrl_out.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle control vectors and IR-derived addresses for each instruction class.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_unit_if #(.DATA_W(16), .RA_W(4)) bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {RegDstWrite,RegWrite,MemToReg,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCWriteCond,ALUSrcB,ALUOp,halted,illegal}
  logic [14:0] ctl;
  assign ctl = {bus.C_RegDstWrite, bus.C_RegWrite, bus.C_MemToReg, bus.C_MemRead,
                bus.C_MemWrite, bus.C_IorD, bus.C_IRWrite, bus.C_PCWrite, bus.C_PCWriteCond,
                bus.C_ALUSrcB, bus.C_ALUOp, bus.halted, bus.illegal};

  localparam logic [14:0] V_ZERO = 15'b000000000_00_00_00;
  localparam logic [14:0] V_FRDY = 15'b000100110_01_00_00;
  localparam logic [14:0] V_FWT  = 15'b000100000_01_00_00;
  localparam logic [14:0] V_DEC  = 15'b000000000_10_00_00;
  localparam logic [14:0] V_DILL = 15'b000000000_10_00_01;
  localparam logic [14:0] V_EXR  = 15'b000000000_00_10_00;
  localparam logic [14:0] V_WBR  = 15'b110000000_00_00_00;
  localparam logic [14:0] V_ADDR = 15'b000000000_10_00_00;
  localparam logic [14:0] V_MRD  = 15'b000101000_00_00_00;
  localparam logic [14:0] V_WBLW = 15'b011000000_00_00_00;
  localparam logic [14:0] V_MWR  = 15'b000011000_00_00_00;
  localparam logic [14:0] V_BR   = 15'b000000001_00_01_00;
  localparam logic [14:0] V_HALT = 15'b000000000_00_00_10;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic test_reset();
    bus.mem_rdata = 16'hFFFF;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (ctl !== V_ZERO) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, V_ZERO);
    end
    n_checks++;
    if (bus.A_RegSWLW !== 4'd0 || bus.A_Offset !== 4'd0) begin
      n_fail++; $display("FAIL reset_ir regswlw=%0d off=%0d exp=0/0", bus.A_RegSWLW, bus.A_Offset);
    end
  endtask

  task automatic test_add();
    logic [14:0] exp [0:4];
    logic        rdy [0:4];
    exp = '{V_FRDY, V_DEC, V_EXR, V_WBR, V_FWT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_rdata = (i == 0) ? 16'h0312 : 16'hEEEE;
      bus.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_fail++; $display("FAIL add_cyc%0d got=%b exp=%b", i + 1, ctl, exp[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (bus.A_WriteRegRT_BT !== 4'd3 || bus.A_ReadReg1RT !== 4'd1 || bus.A_ReadReg2RT !== 4'd2) begin
          n_fail++; $display("FAIL add_addr wr=%0d r1=%0d r2=%0d exp=3/1/2",
                             bus.A_WriteRegRT_BT, bus.A_ReadReg1RT, bus.A_ReadReg2RT);
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [14:0] exp [0:8];
    logic        rdy [0:8];
    exp = '{V_FRDY, V_DEC, V_ADDR, V_MRD, V_MRD, V_MRD, V_MRD, V_WBLW, V_FWT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.mem_rdata = (i == 0) ? 16'h4A53 : 16'h1234;
      bus.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_fail++; $display("FAIL lw_cyc%0d got=%b exp=%b", i + 1, ctl, exp[i]);
      end
      if (i == 7) begin
        n_checks++;
        if (bus.A_RegSWLW !== 4'd10 || bus.A_ReadReg1RT !== 4'd5 || bus.A_Offset !== 4'd3) begin
          n_fail++; $display("FAIL lw_addr swlw=%0d base=%0d off=%0d exp=10/5/3",
                             bus.A_RegSWLW, bus.A_ReadReg1RT, bus.A_Offset);
        end
      end
    end
  endtask

  task automatic test_sw();
    logic [14:0] exp [0:4];
    logic        rdy [0:4];
    exp = '{V_FRDY, V_DEC, V_ADDR, V_MWR, V_FWT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mem_rdata = (i == 0) ? 16'h5B21 : 16'h0000;
      bus.mem_ready = rdy[i];
      #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_fail++; $display("FAIL sw_cyc%0d got=%b exp=%b", i + 1, ctl, exp[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [14:0] exp [0:3];
    exp = '{V_FRDY, V_DEC, V_BR, V_FWT};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rdata = (i == 0) ? 16'h6124 : 16'h0000;
      bus.mem_ready = (i == 0);
      bus.zero      = 1'b1;
      #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_fail++; $display("FAIL beq_cyc%0d got=%b exp=%b", i + 1, ctl, exp[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (bus.A_ReadReg1RT !== 4'd1 || bus.A_ReadReg2RT !== 4'd2 || bus.A_Offset !== 4'd4) begin
          n_fail++; $display("FAIL beq_addr r1=%0d r2=%0d off=%0d exp=1/2/4",
                             bus.A_ReadReg1RT, bus.A_ReadReg2RT, bus.A_Offset);
        end
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_nop_illegal();
    logic [14:0] exp [0:5];
    logic [15:0] ins [0:5];
    exp = '{V_FRDY, V_DEC, V_FRDY, V_DILL, V_FWT, V_FWT};
    ins = '{16'h7000, 16'h0000, 16'h9000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mem_rdata = ins[i];
      bus.mem_ready = (i == 0 || i == 2);
      #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_fail++; $display("FAIL nopill_cyc%0d got=%b exp=%b", i + 1, ctl, exp[i]);
      end
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    bus.mem_rdata = 16'hF000;
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl !== V_FRDY) begin
      n_fail++; $display("FAIL halt_fetch got=%b exp=%b", ctl, V_FRDY);
    end
    @(negedge clk);
    bus.mem_rdata = 16'h0312;
    #1;
    n_checks++;
    if (ctl !== V_DEC) begin
      n_fail++; $display("FAIL halt_decode got=%b exp=%b", ctl, V_DEC);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (ctl !== V_HALT) begin
        n_fail++; $display("FAIL halt_hold%0d got=%b exp=%b", i, ctl, V_HALT);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== V_ZERO) begin
      n_fail++; $display("FAIL halt_rst got=%b exp=%b", ctl, V_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (ctl !== V_FWT) begin
      n_fail++; $display("FAIL halt_release got=%b exp=%b", ctl, V_FWT);
    end
  endtask

  task automatic test_rst_mid_memrd();
    logic [14:0] exp [0:4];
    exp = '{V_FRDY, V_DEC, V_ADDR, V_MRD, V_MRD};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mem_rdata = (i == 0) ? 16'h4A53 : 16'h0000;
      bus.mem_ready = (i == 0);
      #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_fail++; $display("FAIL rstmid_cyc%0d got=%b exp=%b", i + 1, ctl, exp[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== V_ZERO) begin
      n_fail++; $display("FAIL rstmid_during got=%b exp=%b", ctl, V_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctl !== V_FWT) begin
      n_fail++; $display("FAIL rstmid_fetch got=%b exp=%b", ctl, V_FWT);
    end
    n_checks++;
    if (bus.A_RegSWLW !== 4'd0 || bus.A_ReadReg1RT !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_ir swlw=%0d r1=%0d exp=0/0", bus.A_RegSWLW, bus.A_ReadReg1RT);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_beq();
    test_nop_illegal();
    test_halt();
    test_rst_mid_memrd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control sequencer with instruction register (IR) for the 16-bit processor.
- Sits directly upstream of the register file:
  - decodes IR fields into register-file address ports (A_*);
  - drives the register-file write controls (C_RegDstWrite, C_RegWrite, C_MemToReg) and the datapath/memory controls.
- Handshakes with instruction/data memory through mem_ready.

Parameters:
- DATA_W, 16, instruction/data width
- RA_W, 4, register address width
- NOP_INSTR, 16'h7000, IR value after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mem_rdata  in  DATA_W  memory read data; IR source in FETCH
- mem_ready  in  1  memory completes current access this cycle
- zero  in  1  ALU zero flag, valid in BRANCH
- A_ReadReg1RT  out  RA_W  register-file read address 1
- A_ReadReg2RT  out  RA_W  register-file read address 2
- A_Offset  out  RA_W  4-bit immediate/offset field
- A_RegSWLW  out  RA_W  LW destination / SW source register
- A_WriteRegRT_BT  out  RA_W  R-type destination register
- C_RegDstWrite  out  1  1 = write address from A_WriteRegRT_BT; 0 = from A_RegSWLW
- C_RegWrite  out  1  register-file write enable
- C_MemToReg  out  1  1 = write data from MDR; 0 = from ALU
- C_MemRead, C_MemWrite  out  1 each  memory strobes
- C_IorD  out  1  0 = PC address; 1 = ALU address
- C_IRWrite, C_PCWrite, C_PCWriteCond  out  1 each
- C_ALUSrcB  out  2  00 reg, 01 const 2, 10 sign-extended offset
- C_ALUOp  out  2  00 add, 01 sub, 10 funct from opcode[1:0]
- halted  out  1  core stopped
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- ISA: op = IR[15:12].
  - R-type 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR: rd = IR[11:8], rs = IR[7:4], rt = IR[3:0].
  - 0x4 LW, 0x5 SW: rt = IR[11:8], base = IR[7:4], off = IR[3:0].
  - 0x6 BEQ: rs = IR[11:8], rt = IR[7:4], off = IR[3:0].
  - 0x7 NOP; 0xF HALT; 0x8–0xE illegal.
- Address outputs, combinational from IR:
  - A_ReadReg1RT = IR[7:4] for R/LW/SW; IR[11:8] for BEQ.
  - A_ReadReg2RT = IR[3:0] for R; IR[7:4] for BEQ.
  - A_RegSWLW = IR[11:8]; A_WriteRegRT_BT = IR[11:8]; A_Offset = IR[3:0].
- States: FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LW, MEM_WR, BRANCH, HALT.
- FETCH:
  - C_MemRead = 1, C_IorD = 0, C_ALUSrcB = 01, C_ALUOp = 00.
  - Stays in FETCH while mem_ready = 0, with no IR/PC writes.
  - When mem_ready = 1: C_IRWrite = 1 and C_PCWrite = 1 (Mealy); IR <= mem_rdata; next state DECODE.
- DECODE: C_ALUSrcB = 10 (branch target precompute). Next state by opcode:
  - R-type -> EXEC_R; LW/SW -> ADDR; BEQ -> BRANCH; NOP -> FETCH.
  - HALT -> HALT.
  - Illegal -> FETCH, with illegal = 1 for that cycle.
- EXEC_R: C_ALUOp = 10, C_ALUSrcB = 00; next WB_R.
- WB_R: C_RegWrite = 1, C_RegDstWrite = 1, C_MemToReg = 0; next FETCH.
- ADDR: C_ALUSrcB = 10, C_ALUOp = 00; next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: C_MemRead = 1, C_IorD = 1; waits for mem_ready, then WB_LW.
- WB_LW: C_RegWrite = 1, C_RegDstWrite = 0, C_MemToReg = 1; next FETCH.
- MEM_WR: C_MemWrite = 1, C_IorD = 1; waits for mem_ready, then FETCH.
- BRANCH: C_ALUOp = 01, C_ALUSrcB = 00, C_PCWriteCond = 1; next FETCH. PC update is gated externally by zero, which this block does not examine.
- HALT: all strobes 0, halted = 1; left only by rst.
- Latency with mem_ready = 1 throughout:
  - R-type 4 cycles, LW 5, SW 4, BEQ 3, NOP/illegal 2 (FETCH to next FETCH).
- Each added wait cycle in FETCH/MEM_RD/MEM_WR extends the instruction by 1 cycle. Strobes stay asserted and no register or PC write occurs while waiting.
- Any output not listed for a state is 0.
- Reset:
  - While rst = 1: state <= FETCH, IR <= NOP_INSTR, all C_* outputs, halted and illegal are 0.
  - Applies mid-operation, including mid-memory wait and in HALT.
  - First FETCH strobe appears in the cycle after rst deasserts.
- IR changes only on the FETCH handshake edge; address outputs are stable from DECODE through writeback.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD … OP_HALT;
  - ALUOp and ALUSrcB encodings;
  - state enum ctrl_state_t;
  - NOP_INSTR.
- One natural sub-module: instr_field_decode, the combinational mapping from IR to the A_* addresses plus opcode class flags.
- FSM and IR stay in control_unit.

Test Plan:
- Reset, then ADD: rst high 2 cycles -> all C_* = 0. Release with mem_rdata = 16'h0312, mem_ready = 1 -> IR = 0x0312; then DECODE, EXEC_R, WB_R with C_RegWrite = 1, C_RegDstWrite = 1, A_WriteRegRT_BT = 3, A_ReadReg1RT = 1, A_ReadReg2RT = 2; back in FETCH on cycle 5.
- LW 0x4A53 with mem_ready low for 3 cycles in MEM_RD -> C_MemRead/C_IorD held 3 extra cycles. WB_LW asserts C_RegWrite = 1, C_MemToReg = 1, C_RegDstWrite = 0, A_RegSWLW = 10. Total 8 cycles.
- SW 0x5B21 -> C_MemWrite pulses exactly 1 cycle; C_RegWrite never asserted; 4 cycles.
- BEQ 0x6124 -> C_PCWriteCond = 1 in cycle 3, C_ALUOp = 01, A_ReadReg1RT = 1, A_ReadReg2RT = 2, A_Offset = 4; next FETCH.
- Opcode 0x9000 -> illegal = 1 for 1 cycle in DECODE, then FETCH. Opcode 0xF000 -> halted = 1 and stays with no further strobes for 20 cycles; rst releases it.
- rst asserted mid MEM_RD wait -> next cycle state FETCH, C_MemRead = 0 during rst, IR = 16'h7000, no C_RegWrite ever issued.
